// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, fill FSM encoding and helpers.
// Used by the rectangle filler and the display controller.
package vga_pkg;

  localparam int FB_WIDTH_DEF   = 80;
  localparam int FB_HEIGHT_DEF  = 60;
  localparam int ADDR_WIDTH_DEF = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  // Multiply by a constant using only shifts and adds.
  function automatic logic [31:0] row_mul(
    input logic [9:0] a,
    input int         k
  );
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) begin
        acc = acc + ({22'd0, a} << i);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_rect_fill_if.sv
// Command and framebuffer write port bundle for fb_rect_fill.
// master: command issuer; slave: the filler (drives busy/done/wr_*).
interface fb_rect_fill_if
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  start;
  logic [9:0]            x0;
  logic [9:0]            y0;
  logic [9:0]            width;
  logic [9:0]            height;
  logic [2:0]            color;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [2:0]            wr_data;

  modport master (
    output start, x0, y0, width, height, color,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, x0, y0, width, height, color,
    output busy, done, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/fb_rect_fill.sv
// Clipped solid-rectangle fill into the framebuffer, one pixel/cycle.
// Ports: clock, reset (async high), bus (command in, busy/done, wr port).
module fb_rect_fill
  import vga_pkg::*;
#(
  parameter int FB_WIDTH   = FB_WIDTH_DEF,
  parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
  fb_rect_fill_if.slave bus
);

  localparam logic [9:0] FBW = 10'(FB_WIDTH);
  localparam logic [9:0] FBH = 10'(FB_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(FB_WIDTH);

  fill_state_t state, state_n;

  logic [9:0] x0_r, x0_n;
  logic [9:0] y0_r, y0_n;
  logic [9:0] w_r, w_n;
  logic [9:0] h_r, h_n;
  logic [2:0] color_r, color_n;
  logic [9:0] cw_r, cw_n;
  logic [9:0] x_cnt, x_cnt_n;
  logic [9:0] y_cnt, y_cnt_n;
  logic [ADDR_WIDTH-1:0] row_r, row_n;
  logic [ADDR_WIDTH-1:0] addr_r, addr_n;
  logic [2:0] data_r, data_n;
  logic       wr_en_r, wr_en_n;

  logic [9:0] avail_x, avail_y;
  logic [9:0] cw, ch;
  logic       empty;
  logic [ADDR_WIDTH-1:0] first;

  // Clip against the framebuffer edge; only meaningful when !empty.
  always_comb begin
    avail_x = FBW - x0_r;
    avail_y = FBH - y0_r;
    cw = (w_r < avail_x) ? w_r : avail_x;
    ch = (h_r < avail_y) ? h_r : avail_y;
    empty = (x0_r >= FBW) || (y0_r >= FBH) ||
            (w_r == '0) || (h_r == '0);
    first = ADDR_WIDTH'(row_mul(y0_r, FB_WIDTH)) +
            ADDR_WIDTH'(x0_r);
  end

  always_comb begin
    state_n = state;
    x0_n    = x0_r;
    y0_n    = y0_r;
    w_n     = w_r;
    h_n     = h_r;
    color_n = color_r;
    cw_n    = cw_r;
    x_cnt_n = x_cnt;
    y_cnt_n = y_cnt;
    row_n   = row_r;
    addr_n  = addr_r;
    data_n  = data_r;
    wr_en_n = wr_en_r;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          x0_n    = bus.x0;
          y0_n    = bus.y0;
          w_n     = bus.width;
          h_n     = bus.height;
          color_n = bus.color;
          state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (empty) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_FILL;
          wr_en_n = 1'b1;
          addr_n  = first;
          row_n   = first;
          data_n  = color_r;
          cw_n    = cw;
          x_cnt_n = cw - 10'd1;
          y_cnt_n = ch - 10'd1;
        end
      end
      ST_FILL: begin
        // Counters hold writes remaining in row / rows remaining.
        if (x_cnt == '0) begin
          if (y_cnt == '0) begin
            state_n = ST_DONE;
            wr_en_n = 1'b0;
          end else begin
            row_n   = row_r + STEP;
            addr_n  = row_r + STEP;
            x_cnt_n = cw_r - 10'd1;
            y_cnt_n = y_cnt - 10'd1;
          end
        end else begin
          addr_n  = addr_r + 1'b1;
          x_cnt_n = x_cnt - 10'd1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      x0_r    <= '0;
      y0_r    <= '0;
      w_r     <= '0;
      h_r     <= '0;
      color_r <= '0;
      cw_r    <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
      row_r   <= '0;
      addr_r  <= '0;
      data_r  <= '0;
      wr_en_r <= 1'b0;
    end else begin
      state   <= state_n;
      x0_r    <= x0_n;
      y0_r    <= y0_n;
      w_r     <= w_n;
      h_r     <= h_n;
      color_r <= color_n;
      cw_r    <= cw_n;
      x_cnt   <= x_cnt_n;
      y_cnt   <= y_cnt_n;
      row_r   <= row_n;
      addr_r  <= addr_n;
      data_r  <= data_n;
      wr_en_r <= wr_en_n;
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = (state == ST_DONE);
  assign bus.wr_en   = wr_en_r;
  assign bus.wr_addr = addr_r;
  assign bus.wr_data = data_r;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Randomized + directed bench for fb_rect_fill against a pixel-list model.
// Expected writes are enumerated row-major from the clipped rectangle.
module tb_fb_rect_fill;

  localparam int FBW = 80;
  localparam int FBH = 60;
  localparam int AW  = 17;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  fb_rect_fill_if #(.ADDR_WIDTH(AW)) bus ();

  fb_rect_fill #(
    .FB_WIDTH  (FBW),
    .FB_HEIGHT (FBH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
  endtask

  // poke: re-pulse start with other operands mid-fill.
  // abort_at: assert reset right after that many writes (0 = never).
  task automatic run_cmd(
    input int x0, input int y0, input int w, input int h,
    input int c, input bit poke, input int abort_at
  );
    int q[$];
    int cw, ch, n, cyc, nwr, done_cyc;
    bit fin;
    cw = 0;
    ch = 0;
    if (x0 < FBW && y0 < FBH && w > 0 && h > 0) begin
      cw = (w < FBW - x0) ? w : FBW - x0;
      ch = (h < FBH - y0) ? h : FBH - y0;
    end
    for (int y = 0; y < ch; y++)
      for (int x = 0; x < cw; x++)
        q.push_back((y0 + y) * FBW + x0 + x);
    n = cw * ch;
    @(negedge clock);
    bus.x0     = 10'(x0);
    bus.y0     = 10'(y0);
    bus.width  = 10'(w);
    bus.height = 10'(h);
    bus.color  = 3'(c);
    bus.start  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    nwr = 0;
    done_cyc = -1;
    fin = 1'b0;
    while (!fin && cyc < 6000) begin
      chk("busy", 32'(bus.busy), 1);
      chk("wr_en", 32'(bus.wr_en), 32'(cyc >= 2 && cyc <= n + 1));
      if (bus.wr_en) begin
        nwr++;
        if (q.size() == 0) chk("extra_wr", 1, 0);
        else chk("addr", 32'(bus.wr_addr), q.pop_front());
        chk("data", 32'(bus.wr_data), 32'(c));
      end
      if (bus.done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
      if (abort_at > 0 && nwr == abort_at) begin
        reset = 1'b1;
        #1;
        chk_zero_outs("abort");
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          chk("abort_no_done", 32'(bus.done), 0);
          chk("abort_no_wr", 32'(bus.wr_en), 0);
          chk("abort_busy", 32'(bus.busy), 0);
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        return;
      end
      if (poke && cyc == 4) begin
        bus.start = 1'b1;
        bus.color = 3'(~c);
        bus.x0    = 10'd0;
        bus.y0    = 10'd0;
      end
      if (poke && cyc == 5) bus.start = 1'b0;
      if (!fin) begin
        @(negedge clock);
        cyc++;
      end
    end
    chk("done_cyc", 32'(done_cyc), 32'(n + 2));
    chk("n_writes", 32'(nwr), 32'(n));
    chk("q_left", 32'(q.size()), 0);
    @(negedge clock);
    chk("done_pulse", 32'(bus.done), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_wr_en", 32'(bus.wr_en), 0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.x0     = '0;
    bus.y0     = '0;
    bus.width  = '0;
    bus.height = '0;
    bus.color  = '0;
    #2;
    chk_zero_outs("reset");
    repeat (2) @(negedge clock);
    chk_zero_outs("reset_clk");
    @(posedge clock);
    #2;
    reset = 1'b0;

    run_cmd(2, 3, 4, 2, 5, 1'b0, 0);
    run_cmd(78, 58, 10, 10, 3, 1'b0, 0);
    run_cmd(80, 0, 5, 5, 2, 1'b0, 0);
    run_cmd(0, 60, 5, 5, 2, 1'b0, 0);
    run_cmd(10, 10, 0, 5, 2, 1'b0, 0);
    run_cmd(10, 10, 5, 0, 2, 1'b0, 0);
    run_cmd(79, 59, 1, 1, 6, 1'b0, 0);
    run_cmd(0, 0, 80, 60, 7, 1'b0, 0);
    run_cmd(20, 20, 4, 4, 1, 1'b1, 0);
    run_cmd(30, 30, 4, 4, 4, 1'b0, 5);
    run_cmd(30, 30, 4, 4, 6, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      run_cmd($urandom_range(0, 90), $urandom_range(0, 70),
              $urandom_range(0, 24), $urandom_range(0, 24),
              $urandom_range(0, 7), 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
